// File: rtl/bit_serializer.sv
// bit_serializer: loads a WIDTH-bit word through a ready/load handshake and
// shifts it out one bit per clock on `out`, holding `out` low between frames.
// Optional macro BIT_SERIALIZER_PARITY_EN appends one even-parity bit per frame.
module bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             out,
    output logic             valid,
    output logic             done
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef BIT_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {StIdle, StShift, StPar} state_e;
`else
    typedef enum logic [1:0] {StIdle, StShift} state_e;
`endif

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  sreg_q, sreg_d;
    logic              out_q, out_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic              par_q, par_d;
`endif

    // Next-state and registered-output logic; outputs are computed one cycle
    // ahead so every port comes straight from a flop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        out_d   = 1'b0;
        valid_d = 1'b0;
        done_d  = 1'b0;
        ready_d = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            StIdle: begin
                ready_d = 1'b1;
                if (load) begin
                    state_d = StShift;
                    sreg_d  = data_in;
                    cnt_d   = CntW'(WIDTH - 1);
                    out_d   = (MSB_FIRST != 0) ? data_in[WIDTH-1] : data_in[0];
                    valid_d = 1'b1;
                    ready_d = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
                    par_d   = ^data_in;
`endif
                end
            end
            StShift: begin
                if (cnt_q != '0) begin
                    // The register keeps the bit currently on `out` in its
                    // head position, so the next bit is one place behind it.
                    cnt_d   = cnt_q - CntW'(1);
                    valid_d = 1'b1;
                    if (MSB_FIRST != 0) begin
                        sreg_d = sreg_q << 1;
                        out_d  = sreg_q[WIDTH-2];
                    end else begin
                        sreg_d = sreg_q >> 1;
                        out_d  = sreg_q[1];
                    end
`ifndef BIT_SERIALIZER_PARITY_EN
                    done_d = (cnt_q == CntW'(1));
`endif
                end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
                    state_d = StPar;
                    out_d   = par_q;
                    valid_d = 1'b1;
                    done_d  = 1'b1;
`else
                    state_d = StIdle;
                    ready_d = 1'b1;
`endif
                end
            end
`ifdef BIT_SERIALIZER_PARITY_EN
            StPar: begin
                state_d = StIdle;
                ready_d = 1'b1;
            end
`endif
            default: begin
                state_d = StIdle;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset taking priority.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sreg_q  <= '0;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            ready_q <= ready_d;
`ifdef BIT_SERIALIZER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign out   = out_q;
    assign valid = valid_q;
    assign done  = done_q;
    assign ready = ready_q;

endmodule
